delta_dram_arbiter: RTL and testbench
=====================================

# delta_dram_arbiter

Shares the single accelerator DRAM port among the Delta controller's sub-engines: bias loader, input loader, output extractor and weight manager. Today a hard mux selected by controller state drives that port. This block replaces it with a registered round-robin arbiter. Each requester runs one-outstanding read or write transactions, and a requester can optionally lock the port for a burst. A watchdog flags DRAM transactions that never complete.

## Interface
Parameters:
- N_REQ, 4, number of requesters; index 0 bias, 1 input, 2 output, 3 weight.
- ADDR_W, 32, DRAM address width.
- DATA_W, 32, DRAM data width.
- TIMEOUT, 1023, maximum cycles in ACCESS before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_read  in  N_REQ  per-requester read request, level, held until req_done.
- req_write  in  N_REQ  per-requester write request; if read and write are both set, read wins.
- req_lock  in  N_REQ  while high, keeps the port with this requester after it is granted.
- req_addr  in  N_REQ*ADDR_W  packed; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed likewise.
- grant  out  N_REQ  one-hot owner of the current transaction; zero when idle.
- req_done  out  N_REQ  one-cycle pulse to the owner on completion or abort.
- req_rdata  out  DATA_W  registered read data, valid while req_done is high.
- DRAM_Read  out  1;  DRAM_Write  out  1;  DRAM_Address  out  ADDR_W;  DRAM_WriteData  out  DATA_W.
- DRAM_ReadData  in  DATA_W;  DRAM_DataReady  in  1;  DRAM_WriteDone  in  1.
- busy  out  1  high in ACCESS and DONE.
- timeout_err  out  1  sticky; cleared only by reset.

## Operation
- States are IDLE, ACCESS and DONE, held in a registered state plus latched owner, op, address and wdata.
- IDLE, arbitration:
  - If lock_valid is set and the lock owner is requesting, the lock owner wins.
  - Otherwise the winner is the first requester with read|write asserted, searching from last_grant+1 cyclically.
  - The winner's addr, wdata and op are latched, grant is set, and the next state is ACCESS.
  - With no request the block stays in IDLE.
- ACCESS:
  - DRAM_Read or DRAM_Write is driven from the latched op. DRAM_Address and DRAM_WriteData come from the latched values and stay stable for the whole state.
  - A read completes when DRAM_DataReady is sampled high. DRAM_WriteDone is ignored for reads.
  - A write completes when DRAM_WriteDone is sampled high. DRAM_DataReady is ignored for writes.
  - On a read completion, DRAM_ReadData is captured into req_rdata. On any completion the next state is DONE.
  - The watchdog counts ACCESS cycles. At TIMEOUT it sets timeout_err, loads req_rdata=0 and forces DONE (abort).
- DONE:
  - Strobes are low, req_done[owner]=1, last_grant is updated to the owner, and the next state is IDLE.
  - grant stays asserted through DONE and clears on entry to IDLE.
- Lock: lock_valid and lock owner are set on entry to ACCESS when req_lock[owner]=1, and cleared in IDLE when req_lock[owner]=0. A locked owner that drops its request holds the port idle; the other requesters wait.
- DRAM responses arriving in IDLE or DONE are ignored.
- Requesters must drop or change their request in the cycle after req_done. A request still present in IDLE is treated as new.

## Timing
- Reset values:
  - state=IDLE; last_grant=N_REQ-1, so requester 0 has first priority.
  - grant=0, req_done=0, req_rdata=0, DRAM_Read=0, DRAM_Write=0, DRAM_Address=0, DRAM_WriteData=0.
  - busy=0, timeout_err=0, lock_valid=0, watchdog=0.
- All outputs are registered or decoded from registered state; there is no combinational path from the req_* inputs to the DRAM outputs.
- Latency:
  - Request seen at edge t gives grant and strobe from cycle t+1.
  - A response sampled at edge k gives req_done and rdata in cycle k+1, with strobes already low.
  - The next grant is possible from cycle k+2.
  - Minimum is 3 cycles per transaction when the DRAM answers in 1 cycle.
- Reset asserted mid-ACCESS drops the DRAM strobes asynchronously with no req_done. The in-flight DRAM response is lost.
- Watchdog: an abort occurs when the counter equals TIMEOUT. A response arriving in that same cycle takes priority: normal completion, and no error flag.

## Test plan
- Single read: req_read[1]=1, addr 0x100, DataReady after 4 cycles with 0xDEADBEEF. Required: grant=0b0010; DRAM_Read high for 4 cycles at 0x100; req_done[1] and req_rdata=0xDEADBEEF one cycle later.
- Fairness: all four requesters hold reads, DRAM answers in 1 cycle. Required: grants in order 0,1,2,3,0; each requester completes one transaction in every 4-transaction window.
- Lock: req_lock[3]=1 with three back-to-back writes while req_read[0] is pending. Required: all three writes granted to 3 before 0; after req_lock[3]=0, requester 0 is granted next.
- Read/write discrimination: write in flight, DataReady pulses before WriteDone. Required: stays in ACCESS until WriteDone; req_done exactly once; req_rdata unchanged.
- Timeout: TIMEOUT=15, read with no DataReady. Required: abort after 15 ACCESS cycles; timeout_err=1 and stays 1; req_done with req_rdata=0; the next requester is then served.
- Async reset mid-ACCESS: DRAM_Read falls before the next clock edge; all outputs reach their reset values; no req_done; requester 0 has priority afterward.

Source files
------------

// File: rtl/delta_dram_arbiter.sv
`default_nettype none
// ============================================================================
// delta_dram_arbiter : round-robin DRAM port arbiter with burst lock and watchdog
// Rev 1.0
// ============================================================================
module delta_dram_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_read,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      DRAM_Read,
  output logic                      DRAM_Write,
  output logic [ADDR_W-1:0]         DRAM_Address,
  output logic [DATA_W-1:0]         DRAM_WriteData,
  input  logic [DATA_W-1:0]         DRAM_ReadData,
  input  logic                      DRAM_DataReady,
  input  logic                      DRAM_WriteDone,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     lock_owner;
  logic                 lock_valid;
  logic [WD_W-1:0]      watchdog;

  logic [N_REQ-1:0]     req_any;
  logic                 lock_hold;
  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx;
  int                   cand;
  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic [N_REQ-1:0]     win_oh;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 rsp_hit;

  assign req_any   = req_read | req_write;
  assign lock_hold = lock_valid && req_lock[lock_owner];
  assign busy      = (state != IDLE);
  // The latched op is carried by the strobes themselves while in ACCESS.
  assign rsp_hit   = DRAM_Read ? DRAM_DataReady : DRAM_WriteDone;

  // Cyclic search from last_grant+1; descending k lets the nearest candidate win.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % N_REQ;
      if (req_any[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  // An active lock holds the port idle even when its owner is not requesting.
  always_comb begin
    win_valid = lock_hold ? req_any[lock_owner] : rr_found;
    win_idx   = lock_hold ? lock_owner : rr_idx;
    win_oh    = N_REQ'(1) << win_idx;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= '0;
      last_grant     <= LAST_RST;
      lock_owner     <= '0;
      lock_valid     <= 1'b0;
      watchdog       <= '0;
      grant          <= '0;
      req_done       <= '0;
      req_rdata      <= '0;
      DRAM_Read      <= 1'b0;
      DRAM_Write     <= 1'b0;
      DRAM_Address   <= '0;
      DRAM_WriteData <= '0;
      timeout_err    <= 1'b0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (lock_valid && !req_lock[lock_owner]) begin
            lock_valid <= 1'b0;
          end
          if (win_valid) begin
            state          <= ACCESS;
            owner          <= win_idx;
            grant          <= win_oh;
            DRAM_Read      <= req_read[win_idx];
            DRAM_Write     <= ~req_read[win_idx];
            DRAM_Address   <= sel_addr;
            DRAM_WriteData <= sel_wdata;
            watchdog       <= WD_W'(1);
            lock_valid     <= req_lock[win_idx];
            lock_owner     <= win_idx;
          end
        end
        ACCESS: begin
          // A response in the limit cycle still completes normally.
          if (rsp_hit || (watchdog == WD_LIMIT)) begin
            state      <= DONE;
            DRAM_Read  <= 1'b0;
            DRAM_Write <= 1'b0;
            req_done   <= grant;
            watchdog   <= '0;
            if (!rsp_hit) begin
              timeout_err <= 1'b1;
              req_rdata   <= '0;
            end else if (DRAM_Read) begin
              req_rdata <= DRAM_ReadData;
            end
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          grant      <= '0;
          last_grant <= owner;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delta_dram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_delta_dram_arbiter : self-checking bench with a transaction-level model
// Rev 1.0
// ============================================================================
module tb_delta_dram_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_read, req_write, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant, req_done;
  logic [DW-1:0]   req_rdata;
  logic            DRAM_Read, DRAM_Write;
  logic [AW-1:0]   DRAM_Address;
  logic [DW-1:0]   DRAM_WriteData, DRAM_ReadData;
  logic            DRAM_DataReady, DRAM_WriteDone;
  logic            busy, timeout_err;

  logic [AW-1:0]   a_addr  [N];
  logic [DW-1:0]   a_wdata [N];

  int              checks = 0;
  int              errors = 0;

  // reference model state
  logic [1:0]      exp_last;
  bit              lock_v;
  logic [1:0]      lock_o;
  logic [DW-1:0]   exp_rdata;

  assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
  assign req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};

  delta_dram_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .req_done(req_done), .req_rdata(req_rdata),
    .DRAM_Read(DRAM_Read), .DRAM_Write(DRAM_Write),
    .DRAM_Address(DRAM_Address), .DRAM_WriteData(DRAM_WriteData),
    .DRAM_ReadData(DRAM_ReadData), .DRAM_DataReady(DRAM_DataReady),
    .DRAM_WriteDone(DRAM_WriteDone),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    oh = 4'b0001 << i;
  endfunction

  // Spec-level arbitration: lock owner if the lock is still held, else the
  // first requester after the last winner, going around the ring.
  task automatic pick(output int w);
    int c;
    logic [N-1:0] any;
    any = req_read | req_write;
    w = -1;
    if (lock_v && req_lock[lock_o]) begin
      if (any[lock_o]) w = int'(lock_o);
    end else begin
      lock_v = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (int'(exp_last) + k) % N;
        if (w < 0 && any[c[1:0]]) w = c;
      end
    end
  endtask

  // One transaction: wait for the grant, answer after lat ACCESS cycles,
  // return in the DONE cycle.
  task automatic do_txn(input int lat, input logic [DW-1:0] rd, input bit glitch,
                        output int waited);
    int w;
    bit is_rd;
    logic [AW-1:0] ea;
    pick(w);
    chk("model_has_winner", (w >= 0), 1'b1);
    if (w < 0) w = 0;
    is_rd  = req_read[w[1:0]];
    ea     = a_addr[w[1:0]];
    waited = 0;
    while (!(DRAM_Read || DRAM_Write) && waited < 10) begin
      step();
      waited++;
    end
    chk("grant_wait", (waited < 10), 1'b1);
    lock_v = req_lock[w[1:0]];
    lock_o = w[1:0];
    chk("grant", grant, oh(w));
    chk("busy_access", busy, 1'b1);
    if (!is_rd) chk("wdata", DRAM_WriteData, a_wdata[w[1:0]]);
    for (int c = 1; c <= lat; c++) begin
      chk("addr_stable", DRAM_Address, ea);
      chk("strobe", {DRAM_Read, DRAM_Write}, {is_rd, !is_rd});
      chk("no_early_done", req_done, 4'b0000);
      if (c == lat) begin
        if (is_rd) begin
          DRAM_DataReady = 1'b1;
          DRAM_ReadData  = rd;
        end else begin
          DRAM_WriteDone = 1'b1;
        end
      end else if (glitch && c == 1) begin
        DRAM_DataReady = 1'b1;
        DRAM_ReadData  = $urandom;
      end
      step();
      DRAM_DataReady = 1'b0;
      DRAM_WriteDone = 1'b0;
      DRAM_ReadData  = $urandom;
    end
    if (is_rd) exp_rdata = rd;
    exp_last = w[1:0];
    chk("req_done", req_done, oh(w));
    chk("rdata", req_rdata, exp_rdata);
    chk("strobes_low_done", {DRAM_Read, DRAM_Write}, 2'b00);
    chk("grant_in_done", grant, oh(w));
    chk("busy_done", busy, 1'b1);
  endtask

  initial begin
    int wt, acc;
    logic [DW-1:0] v;
    reset = 1'b1;
    req_read = '0; req_write = '0; req_lock = '0;
    DRAM_ReadData = '0; DRAM_DataReady = 1'b0; DRAM_WriteDone = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = $urandom;
      a_wdata[i] = $urandom;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_done", req_done, 4'b0000);
    chk("rst_rdata", req_rdata, 32'h0);
    chk("rst_strobes", {DRAM_Read, DRAM_Write}, 2'b00);
    chk("rst_addr", DRAM_Address, 32'h0);
    chk("rst_wdata", DRAM_WriteData, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    reset = 1'b0;
    exp_last = 2'd3; lock_v = 1'b0; lock_o = 2'd0; exp_rdata = '0;

    // DRAM responses while idle are ignored
    DRAM_DataReady = 1'b1; DRAM_WriteDone = 1'b1; DRAM_ReadData = $urandom;
    repeat (3) step();
    chk("idle_rsp_grant", grant, 4'b0000);
    chk("idle_rsp_done", req_done, 4'b0000);
    chk("idle_rsp_rdata", req_rdata, 32'h0);
    chk("idle_rsp_busy", busy, 1'b0);
    DRAM_DataReady = 1'b0; DRAM_WriteDone = 1'b0;

    // fairness: all four hold reads
    req_read = 4'hF;
    for (int i = 0; i < 12; i++) begin
      v = $urandom;
      do_txn($urandom_range(1, 3), v, 1'b0, wt);
      chk("fair_order", grant, oh(i % 4));
      if (i > 0) chk("fair_gap", wt, 2);
    end
    req_read = '0;
    step();

    // single read
    a_addr[1] = 32'h100;
    req_read  = 4'b0010;
    do_txn(4, 32'hDEADBEEF, 1'b0, wt);
    chk("single_rdata", req_rdata, 32'hDEADBEEF);
    req_read = '0;
    step();
    chk("idle_grant_clear", grant, 4'b0000);
    chk("idle_busy", busy, 1'b0);

    // lock burst by requester 3 while requester 0 waits
    req_write = 4'b1000; req_lock = 4'b1000;
    a_wdata[3] = $urandom; a_addr[3] = $urandom;
    do_txn($urandom_range(1, 3), '0, 1'b0, wt);
    req_read = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      a_wdata[3] = $urandom; a_addr[3] = $urandom;
      do_txn($urandom_range(1, 3), '0, 1'b0, wt);
      chk("lock_keeps_3", grant, 4'b1000);
    end
    req_write = '0;
    repeat (4) begin
      step();
      chk("lock_hold_idle", grant, 4'b0000);
      chk("lock_hold_busy", busy, 1'b0);
    end
    req_lock = '0;
    do_txn(2, $urandom, 1'b0, wt);
    chk("unlock_grant0", grant, 4'b0001);
    req_read = '0;

    // write with stray DataReady before WriteDone
    req_write = 4'b0100; a_wdata[2] = $urandom;
    v = exp_rdata;
    do_txn(4, '0, 1'b1, wt);
    chk("glitch_rdata_kept", req_rdata, v);
    req_write = '0;
    step();
    chk("done_once", req_done, 4'b0000);

    // randomized request mixes
    for (int i = 0; i < 24; i++) begin
      req_read  = 4'($urandom);
      req_write = 4'($urandom);
      if ((req_read | req_write) == 4'b0000) req_write = oh($urandom_range(0, 3));
      for (int j = 0; j < N; j++) begin
        a_addr[j]  = $urandom;
        a_wdata[j] = $urandom;
      end
      do_txn($urandom_range(1, 6), $urandom, 1'b0, wt);
    end
    req_read = '0; req_write = '0;
    step();

    // response in the watchdog limit cycle completes normally
    req_read = 4'b0010;
    v = $urandom;
    do_txn(TO, v, 1'b0, wt);
    chk("limit_rsp_rdata", req_rdata, v);
    chk("limit_rsp_no_err", timeout_err, 1'b0);
    req_read = '0;
    step();

    // watchdog abort, then the next requester is served
    req_read = 4'b0100; req_write = 4'b1000;
    pick(wt);
    acc = 0;
    for (int c = 0; c < 10 && !DRAM_Read; c++) step();
    chk("to_grant", grant, 4'b0100);
    for (int c = 0; c < 40 && req_done == 4'b0000; c++) begin
      if (DRAM_Read) acc++;
      step();
    end
    chk("to_cycles", acc, TO);
    chk("to_done", req_done, 4'b0100);
    chk("to_rdata", req_rdata, 32'h0);
    chk("to_err", timeout_err, 1'b1);
    exp_rdata = '0; exp_last = 2'd2; lock_v = 1'b0;
    req_read = '0;
    do_txn(2, '0, 1'b0, wt);
    chk("to_next", grant, 4'b1000);
    chk("to_err_sticky", timeout_err, 1'b1);
    req_write = '0;
    step();

    // asynchronous reset mid-ACCESS
    req_read = 4'b0010;
    for (int c = 0; c < 10 && !DRAM_Read; c++) step();
    chk("ar_started", DRAM_Read, 1'b1);
    step();
    #3;
    reset = 1'b1;
    DRAM_DataReady = 1'b1;
    #1;
    chk("ar_read_low", DRAM_Read, 1'b0);
    chk("ar_grant", grant, 4'b0000);
    chk("ar_busy", busy, 1'b0);
    chk("ar_terr", timeout_err, 1'b0);
    chk("ar_addr", DRAM_Address, 32'h0);
    step();
    chk("ar_no_done", req_done, 4'b0000);
    chk("ar_rdata", req_rdata, 32'h0);
    reset = 1'b0;
    DRAM_DataReady = 1'b0;
    exp_last = 2'd3; lock_v = 1'b0; exp_rdata = '0;
    req_read = 4'b1011;
    do_txn(1, $urandom, 1'b0, wt);
    chk("ar_prio0", grant, 4'b0001);
    req_read = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
